// File: rtl/guess_pkg.sv
// Shared definitions for the guess entry stage: guess geometry, FSM encoding,
// default debounce length and small digit-mask helpers.
package guess_pkg;

    localparam int NUM_DIGITS          = 4;
    localparam int BCD_W               = 4;
    localparam int GUESS_W             = NUM_DIGITS * BCD_W;
    localparam int NUM_KEYS            = 10;
    localparam int DEBOUNCE_CYCLES_DEF = 500000;

    typedef enum logic {
        COLLECT = 1'b0,
        VALID   = 1'b1
    } state_e;

    function automatic logic [3:0] count_ones(input logic [NUM_KEYS-1:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

    // Only meaningful for a one-hot mask; returns the lowest set position.
    function automatic logic [3:0] onehot_to_bcd(input logic [NUM_KEYS-1:0] v);
        logic [3:0] d;
        d = 4'd0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (v[i]) begin
                d = 4'(i);
            end else begin
                d = d;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button conditioner: two-flop synchroniser, hold-time debounce and
// a single-cycle pulse on each debounced press (release is silent).
module btn_debounce
    import guess_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             deb_r;
    logic             deb_prev_r;
    logic             press_r;
    logic [CNT_W-1:0] cnt_r;

    // Synchronise, debounce and edge-detect the raw button level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r    <= 1'b0;
            sync2_r    <= 1'b0;
            deb_r      <= 1'b0;
            deb_prev_r <= 1'b0;
            press_r    <= 1'b0;
            cnt_r      <= '0;
        end else begin
            sync1_r    <= btn;
            sync2_r    <= sync1_r;
            deb_prev_r <= deb_r;
            press_r    <= deb_r & ~deb_prev_r;
            if (sync2_r != deb_r) begin
                if (cnt_r == CNT_MAX) begin
                    deb_r <= sync2_r;
                    cnt_r <= '0;
                end else begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end
            end else begin
                cnt_r <= '0;
            end
        end
    end

    assign press = press_r;

endmodule

// File: rtl/guess_entry.sv
// Turns ten digit buttons plus clear into a 4-digit BCD guess with no repeated
// digits, offered to the scoring logic through a valid/ready handshake.
module guess_entry
    import guess_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] btn_digit,
    input  logic                btn_clr,
    input  logic                guess_ready,
    output logic [GUESS_W-1:0]  guess,
    output logic                guess_valid,
    output logic [2:0]          digit_count,
    output logic [NUM_KEYS-1:0] digit_used,
    output logic                entry_err
);

    localparam logic [2:0] LAST_COUNT = 3'(NUM_DIGITS - 1);

    logic [NUM_KEYS:0]   raw_s;
    logic [NUM_KEYS:0]   press_s;
    logic [NUM_KEYS-1:0] digit_press_s;
    logic                clr_press_s;
    logic [3:0]          n_press_s;
    logic [3:0]          digit_s;

    state_e              state_r,  state_nx_s;
    logic [GUESS_W-1:0]  guess_r,  guess_nx_s;
    logic [2:0]          count_r,  count_nx_s;
    logic [NUM_KEYS-1:0] used_r,   used_nx_s;
    logic                err_r,    err_nx_s;

    assign raw_s = {btn_clr, btn_digit};

    for (genvar i = 0; i <= NUM_KEYS; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_debounce (
            .clk   (clk),
            .rst   (rst),
            .btn   (raw_s[i]),
            .press (press_s[i])
        );
    end

    assign digit_press_s = press_s[NUM_KEYS-1:0];
    assign clr_press_s   = press_s[NUM_KEYS];
    assign n_press_s     = count_ones(digit_press_s);
    assign digit_s       = onehot_to_bcd(digit_press_s);

    // Event arbitration and next-state decode; clear outranks any digit.
    always_comb begin
        state_nx_s = state_r;
        guess_nx_s = guess_r;
        count_nx_s = count_r;
        used_nx_s  = used_r;
        err_nx_s   = 1'b0;
        case (state_r)
            COLLECT: begin
                if (clr_press_s) begin
                    guess_nx_s = '0;
                    count_nx_s = 3'd0;
                    used_nx_s  = '0;
                end else if (n_press_s > 4'd1) begin
                    err_nx_s = 1'b1;
                end else if (n_press_s == 4'd1) begin
                    if ((used_r & digit_press_s) != '0) begin
                        err_nx_s = 1'b1;
                    end else begin
                        guess_nx_s = {guess_r[GUESS_W-BCD_W-1:0], digit_s};
                        used_nx_s  = used_r | digit_press_s;
                        count_nx_s = count_r + 3'd1;
                        if (count_r == LAST_COUNT) begin
                            state_nx_s = VALID;
                        end else begin
                            state_nx_s = COLLECT;
                        end
                    end
                end else begin
                    state_nx_s = COLLECT;
                end
            end
            VALID: begin
                if (guess_ready) begin
                    state_nx_s = COLLECT;
                    guess_nx_s = '0;
                    count_nx_s = 3'd0;
                    used_nx_s  = '0;
                end else begin
                    state_nx_s = VALID;
                end
            end
            default: begin
                state_nx_s = COLLECT;
            end
        endcase
    end

    // Entry state and all outputs are held in registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= COLLECT;
            guess_r <= '0;
            count_r <= 3'd0;
            used_r  <= '0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            guess_r <= guess_nx_s;
            count_r <= count_nx_s;
            used_r  <= used_nx_s;
            err_r   <= err_nx_s;
        end
    end

    assign guess       = guess_r;
    assign guess_valid = (state_r == VALID);
    assign digit_count = count_r;
    assign digit_used  = used_r;
    assign entry_err   = err_r;

endmodule

// File: tb/tb_guess_entry.sv
// Randomised and directed bench for guess_entry against an event-level model
// of the entry rules (digit list, clear, duplicates, handshake).
module tb_guess_entry;

    localparam int DEB = 4;
    localparam int LAT = DEB + 4;

    logic        clk;
    logic        rst;
    logic [9:0]  btn_digit;
    logic        btn_clr;
    logic        guess_ready;
    logic [15:0] guess;
    logic        guess_valid;
    logic [2:0]  digit_count;
    logic [9:0]  digit_used;
    logic        entry_err;

    int n_checks = 0;
    int n_fail   = 0;
    int err_cycles = 0;
    int mdl_q[$];

    guess_entry #(.DEBOUNCE_CYCLES(DEB), .CNT_W(20)) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_digit   (btn_digit),
        .btn_clr     (btn_clr),
        .guess_ready (guess_ready),
        .guess       (guess),
        .guess_valid (guess_valid),
        .digit_count (digit_count),
        .digit_used  (digit_used),
        .entry_err   (entry_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every cycle the error pulse is observed high.
    always @(negedge clk) begin
        if (rst && entry_err) err_cycles++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mdl_guess();
        int g = 0;
        foreach (mdl_q[i]) g = g * 16 + mdl_q[i];
        return 16'(g);
    endfunction

    function automatic logic [9:0] mdl_used();
        logic [9:0] u = 10'd0;
        foreach (mdl_q[i]) u[mdl_q[i]] = 1'b1;
        return u;
    endfunction

    // Apply one batch of simultaneous press events to the model.
    task automatic model_apply(input logic [9:0] m, input logic c, output int exp_err);
        int d = 0;
        exp_err = 0;
        if (mdl_q.size() == 4) return;
        if (c) begin
            mdl_q.delete();
        end else if ($countones(m) > 1) begin
            exp_err = 1;
        end else if ($countones(m) == 1) begin
            for (int i = 0; i < 10; i++) if (m[i]) d = i;
            foreach (mdl_q[i]) if (mdl_q[i] == d) exp_err = 1;
            if (exp_err == 0) mdl_q.push_back(d);
        end
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, ".guess"}, 32'(guess), 32'(mdl_guess()));
        check_eq({tag, ".count"}, 32'(digit_count), 32'(mdl_q.size()));
        check_eq({tag, ".used"},  32'(digit_used), 32'(mdl_used()));
        check_eq({tag, ".valid"}, 32'(guess_valid), 32'(mdl_q.size() == 4));
    endtask

    task automatic press(input string tag, input logic [9:0] m, input logic c);
        int e0, exp_err;
        e0 = err_cycles;
        @(negedge clk);
        btn_digit = m;
        btn_clr   = c;
        repeat ($urandom_range(8, 12)) @(negedge clk);
        btn_digit = 10'd0;
        btn_clr   = 1'b0;
        repeat ($urandom_range(10, 14)) @(negedge clk);
        model_apply(m, c, exp_err);
        check_state(tag);
        check_eq({tag, ".err"}, 32'(err_cycles - e0), 32'(exp_err));
    endtask

    task automatic handshake(input string tag);
        @(negedge clk);
        guess_ready = 1'b1;
        @(negedge clk);
        guess_ready = 1'b0;
        if (mdl_q.size() == 4) mdl_q.delete();
        check_state(tag);
    endtask

    task automatic enter4(input string tag, input int a, input int b, input int c, input int d);
        press(tag, 10'd1 << a, 1'b0);
        press(tag, 10'd1 << b, 1'b0);
        press(tag, 10'd1 << c, 1'b0);
        press(tag, 10'd1 << d, 1'b0);
    endtask

    initial begin
        int vcnt, e0, op, a, b;
        rst = 1'b0; btn_digit = 10'd0; btn_clr = 1'b0; guess_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst.err", 32'(entry_err), 32'd0);
        check_state("rst");
        rst = 1'b1;

        enter4("seq1234", 1, 2, 3, 4);
        check_eq("g1234", 32'(guess), 32'h1234);
        check_eq("used1234", 32'(digit_used), 32'h01e);
        vcnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (guess_valid) vcnt++;
        end
        check_eq("valid_hold", 32'(vcnt), 32'd20);
        press("valid_ign", 10'd1 << 5, 1'b0);
        press("valid_clr", 10'd0, 1'b1);
        handshake("hs1");

        // Contact bounce on digit 7 shorter than the debounce window.
        e0 = err_cycles;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            btn_digit[7] = ~btn_digit[7];
            repeat (2) @(negedge clk);
        end
        btn_digit[7] = 1'b1;
        repeat (10) @(negedge clk);
        btn_digit = 10'd0;
        repeat (12) @(negedge clk);
        mdl_q.push_back(7);
        check_state("bounce");
        check_eq("bounce.g", 32'(guess), 32'h0007);
        check_eq("bounce.err", 32'(err_cycles - e0), 32'd0);

        press("clr", 10'd0, 1'b1);
        press("dup5a", 10'd1 << 5, 1'b0);
        press("dup5b", 10'd1 << 5, 1'b0);
        check_eq("dup.g", 32'(guess), 32'h0005);
        press("simul23", 10'b0000001100, 1'b0);
        press("clr2", 10'd0, 1'b1);
        press("d8", 10'd1 << 8, 1'b0);
        press("d6", 10'd1 << 6, 1'b0);
        press("clr9", 10'd1 << 9, 1'b1);
        check_eq("clr9.g", 32'(guess), 32'h0000);

        enter4("seq9081", 9, 0, 8, 1);
        check_eq("g9081", 32'(guess), 32'h9081);
        handshake("hs2");
        check_eq("hs2.valid", 32'(guess_valid), 32'd0);
        enter4("again", 1, 2, 3, 4);
        check_eq("again.g", 32'(guess), 32'h1234);
        handshake("hs3");

        // Asynchronous reset mid-entry, then a button held through release.
        press("r2", 10'd1 << 2, 1'b0);
        press("r4", 10'd1 << 4, 1'b0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_eq("arst.g", 32'(guess), 32'h0);
        check_eq("arst.count", 32'(digit_count), 32'd0);
        mdl_q.delete();
        btn_digit = 10'd1 << 3;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= LAT; k++) begin
            @(posedge clk);
            #1;
            if (k == LAT - 1) check_eq("lat.early", 32'(digit_count), 32'd0);
            if (k == LAT)     check_eq("lat.hit", 32'(digit_count), 32'd1);
        end
        btn_digit = 10'd0;
        repeat (12) @(negedge clk);
        mdl_q.push_back(3);
        check_state("held");

        for (int it = 0; it < 60; it++) begin
            op = $urandom_range(0, 9);
            a  = $urandom_range(0, 9);
            b  = (a + 1 + $urandom_range(0, 8)) % 10;
            if (op <= 5)      press("rnd.single", 10'd1 << a, 1'b0);
            else if (op == 6) press("rnd.pair", (10'd1 << a) | (10'd1 << b), 1'b0);
            else if (op == 7) press("rnd.clr", 10'd0, 1'b1);
            else if (op == 8) press("rnd.clrdig", 10'd1 << a, 1'b1);
            else              handshake("rnd.hs");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/guess_entry.md
Name: guess_entry

Overview:
- Upstream stage of the Bulls-and-Cows game logic: turns the ten raw digit push-buttons plus a clear button into one 4-digit BCD guess.
- Synchronises and debounces every button and detects presses.
- Builds the guess one digit at a time and rejects repeated digits.
- Presents the finished 16-bit guess to the scoring logic with a valid/ready handshake; the guess stays stable until the scoring logic accepts it.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive cycles a synchronised button level must hold before it is accepted (10 ms at 50 MHz); the bench uses 4.
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- btn_digit  in  10  raw digit buttons, bit i = digit i, active-high, asynchronous to clk.
- btn_clr  in  1  raw clear button, active-high, asynchronous to clk.
- guess_ready  in  1  scoring logic accepts the guess.
- guess  out  16  BCD guess, first-entered digit in [15:12], last-entered digit in [3:0].
- guess_valid  out  1  guess is complete and stable.
- digit_count  out  3  digits entered so far, 0..4.
- digit_used  out  10  one-hot mask of digits already in the guess.
- entry_err  out  1  one-cycle pulse when a press is rejected.

Behaviour:
- Reset (rst=0, asynchronous): guess=0, guess_valid=0, digit_count=0, digit_used=0, entry_err=0, state=COLLECT, all sync/debounce registers and counters=0.
- Input conditioning, per button (11 total):
  - Two-flop synchroniser.
  - Debounce: the counter increments while the synced level differs from the debounced level and resets to 0 when they match. When the counter reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
  - Press event: one-cycle pulse on a 0->1 transition of the debounced level. Release produces no event.
- Latency: a clean press held from cycle 0 gives its press event at cycle DEBOUNCE_CYCLES+2. The guess register and outputs update on the following edge.
- More than one digit event in the same cycle: all of them are dropped and entry_err pulses.
- State COLLECT (guess_valid=0), on a single digit event d:
  - If digit_used[d]=1: drop the press, entry_err=1 for one cycle.
  - Otherwise: guess <= {guess[11:0], d}, digit_used[d] <= 1, digit_count <= digit_count+1.
  - If this makes digit_count 4, go to VALID on the same edge.
  - Digit 0 is legal in any position, including the first.
- Clear event in COLLECT: guess=0, digit_count=0, digit_used=0.
  - Clear and digit event in the same cycle: clear wins, the digit is dropped, no entry_err.
- State VALID:
  - guess_valid=1; guess, digit_count=4 and digit_used are held.
  - Digit and clear events are ignored, with no entry_err.
  - Handshake completes on the first rising edge with guess_valid=1 and guess_ready=1. On that edge: state=COLLECT, guess_valid=0, digit_count=0, digit_used=0, guess=0.
  - guess_ready while in COLLECT has no effect.
- A press already debounced during VALID does not re-fire after the transition to COLLECT; only a new 0->1 transition does.
- Reset mid-entry or mid-VALID: immediate return to the reset values. A button still held through reset release generates a press event once debounced, because the debounced level restarts at 0.

Decomposition:
- Shared package guess_pkg:
  - NUM_DIGITS=4 and BCD_W=4.
  - State encoding: COLLECT=1'b0, VALID=1'b1.
  - Default DEBOUNCE_CYCLES.
- Sub-module btn_debounce (synchroniser, counter, debounced level, press pulse), parameterised by DEBOUNCE_CYCLES/CNT_W, instantiated 11 times.
- The top of guess_entry holds the event arbitration, the shift register, the used mask and the FSM.

Test Plan (DEBOUNCE_CYCLES=4):
- Clean presses 1,2,3,4, each held 10 cycles with 10-cycle gaps, guess_ready=0:
  - guess=16'h1234, digit_count=4, digit_used=10'b0000011110, guess_valid=1.
  - guess_valid stays 1 for 20 further cycles, and a press of 5 changes nothing.
- Bounce: digit 7 toggled every 2 cycles for 12 cycles, then held high 10 cycles:
  - Exactly one event, guess=16'h0007, digit_count=1.
- Duplicate: enter 5,5:
  - digit_count=1, guess=16'h0005, entry_err high exactly one cycle on the second event.
- Simultaneous: digits 2 and 3 pressed on the same cycle -> entry_err pulse, digit_count unchanged. Clear pressed with digit 9 after entering 8,6 -> guess=0, digit_count=0, no entry_err.
- Handshake: after 16'h9081 is VALID, raise guess_ready for one cycle -> next edge guess_valid=0, digit_count=0, digit_used=0. Then entering 1,2,3,4 yields 16'h1234 again.
- Reset: assert rst=0 mid-entry with two digits stored -> guess=0, digit_count=0 immediately without a clock edge. After release, a held button produces one event after DEBOUNCE_CYCLES+2 cycles.
